tlx_afu_cmd_buffer: RTL and testbench
=====================================

TLX_AFU_CMD_BUFFER -- requirements
Module: tlx_afu_cmd_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning command entries held; power of two, 2..16.
REQ-002 SHALL have parameter PA_W, default 64, meaning physical-address width.
REQ-003 SHALL have port ha_pclock  in  1  meaning sole clock; all state updates on rising edge.
REQ-004 SHALL have port ha_preset_n  in  1  meaning reset; asynchronous, active-low.
REQ-005 SHALL have port tlx_afu_cmd_valid  in  1  meaning TLX presents one command this cycle.
REQ-006 SHALL have port tlx_afu_cmd_opcode  in  8  meaning command opcode.
REQ-007 SHALL have port tlx_afu_cmd_capptag  in  16  meaning command tag.
REQ-008 SHALL have port tlx_afu_cmd_pa  in  PA_W  meaning command address.
REQ-009 SHALL have port afu_tlx_cmd_credit  out  1  meaning one-cycle pulse returning one credit.
REQ-010 SHALL have port afu_tlx_cmd_initial_credit  out  5  meaning constant DEPTH.
REQ-011 SHALL have port cmd_out_valid  out  1  meaning head entry available to AFU.
REQ-012 SHALL have port cmd_out_ready  in  1  meaning AFU accepts head entry.
REQ-013 SHALL have ports cmd_out_opcode / cmd_out_capptag / cmd_out_pa  out  8 / 16 / PA_W  meaning head entry fields.
REQ-014 SHALL have port occupancy  out  5  meaning entries currently stored.
REQ-015 SHALL have port overflow_err  out  1  meaning sticky: command arrived with no free entry.

Function
REQ-016 SHALL store entries in a DEPTH-deep register array with write pointer, read pointer (log2(DEPTH) bits, wrap DEPTH-1 -> 0) and count (0..DEPTH).
REQ-017 SHALL define push = tlx_afu_cmd_valid and (count < DEPTH or pop); pop = cmd_out_valid and cmd_out_ready.
REQ-018 SHALL on push write opcode/capptag/pa at write pointer and advance it; on pop advance read pointer.
REQ-019 SHALL update count +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-020 SHALL drive cmd_out_valid = (count != 0) and cmd_out_* combinationally from entry at read pointer (first-word fall-through).
REQ-021 SHALL give latency: command pushed at edge N visible on cmd_out_* after edge N when buffer was empty; no bypass from input to output in the same cycle.
REQ-022 SHALL hold cmd_out_* stable while cmd_out_valid=1 and cmd_out_ready=0.
REQ-023 SHALL on tlx_afu_cmd_valid=1 with count=DEPTH and no pop drop the command, leave array/pointers/count unchanged, and set overflow_err=1 until reset.
REQ-024 SHALL accept a push when count=DEPTH and pop occurs in the same cycle (entry freed and reused; count stays DEPTH).
REQ-025 SHALL register afu_tlx_cmd_credit = pop of the previous cycle (one pulse per popped entry, one cycle after the pop edge); never pulse for dropped commands.
REQ-026 SHALL drive occupancy = count and afu_tlx_cmd_initial_credit = DEPTH constantly.
REQ-027 SHALL guarantee total credits returned never exceed total commands accepted.

Reset
REQ-028 SHALL on ha_preset_n=0 immediately clear pointers, count, afu_tlx_cmd_credit, overflow_err to 0; cmd_out_valid=0; occupancy=0.
REQ-029 SHALL discard all stored entries on reset mid-operation, including an in-flight credit pulse; array contents need not be cleared.
REQ-030 SHALL ignore all inputs while ha_preset_n=0 and resume normal operation on the first rising edge after deassertion.

Verification
REQ-031 SHALL cover: single push opcode=0x20 tag=0x0001 into empty buffer, cmd_out_ready=1 -> cmd_out_valid=1 next cycle with those fields, pop, credit pulse one cycle later, occupancy back to 0.
REQ-032 SHALL cover: 8 back-to-back pushes tags 0..7, ready=0 -> occupancy=8, head tag 0 held stable; then ready=1 -> tags 0..7 out in order, exactly 8 credit pulses.
REQ-033 SHALL cover: buffer full, ninth push tag 0x00FF without pop -> dropped, overflow_err=1 sticky, occupancy=8, no tag 0x00FF ever output.
REQ-034 SHALL cover: buffer full, push tag 0x0009 with simultaneous pop -> accepted, occupancy stays 8, tag 0x0009 emerges last.
REQ-035 SHALL cover: 20 pushes/pops with random ready across pointer wrap -> output order equals input order, credits equal pops.
REQ-036 SHALL cover: assert ha_preset_n=0 asynchronously mid-cycle with occupancy=5 and overflow_err=1 -> all outputs 0 immediately; after release a new push tag 0x0042 is the first output.

Source files
------------

// File: rtl/tlx_afu_cmd_buffer_if.sv
// Command path between the TLX receive side, the command buffer and the AFU.
//   TLX -> buffer : tlx_afu_cmd_valid/opcode/capptag/pa
//   buffer -> TLX : afu_tlx_cmd_credit (one pulse per freed entry), afu_tlx_cmd_initial_credit
//   buffer -> AFU : cmd_out_valid/opcode/capptag/pa
//   AFU -> buffer : cmd_out_ready
// The slave modport is the buffer's view; the master modport is the environment's view.
interface tlx_afu_cmd_buffer_if #(
  parameter int unsigned PA_W = 64
);
  logic            tlx_afu_cmd_valid;
  logic [7:0]      tlx_afu_cmd_opcode;
  logic [15:0]     tlx_afu_cmd_capptag;
  logic [PA_W-1:0] tlx_afu_cmd_pa;
  logic            afu_tlx_cmd_credit;
  logic [4:0]      afu_tlx_cmd_initial_credit;
  logic            cmd_out_valid;
  logic            cmd_out_ready;
  logic [7:0]      cmd_out_opcode;
  logic [15:0]     cmd_out_capptag;
  logic [PA_W-1:0] cmd_out_pa;

  modport slave (
    input  tlx_afu_cmd_valid, tlx_afu_cmd_opcode, tlx_afu_cmd_capptag, tlx_afu_cmd_pa,
    input  cmd_out_ready,
    output afu_tlx_cmd_credit, afu_tlx_cmd_initial_credit,
    output cmd_out_valid, cmd_out_opcode, cmd_out_capptag, cmd_out_pa
  );

  modport master (
    output tlx_afu_cmd_valid, tlx_afu_cmd_opcode, tlx_afu_cmd_capptag, tlx_afu_cmd_pa,
    output cmd_out_ready,
    input  afu_tlx_cmd_credit, afu_tlx_cmd_initial_credit,
    input  cmd_out_valid, cmd_out_opcode, cmd_out_capptag, cmd_out_pa
  );
endinterface

// File: rtl/tlx_afu_cmd_buffer.sv
// Credit-managed command buffer between TLX and an AFU.
// Commands from TLX are stored in a DEPTH-entry circular buffer and presented to the AFU in
// order with first-word fall-through. Each entry consumed by the AFU returns one credit to TLX
// one cycle later. A command arriving with no free entry is dropped and flags overflow_err.
// Ports:
//   ha_pclock    : clock, all state on rising edge
//   ha_preset_n  : asynchronous active-low reset
//   cmd_if       : command interface (slave view)
//   occupancy    : number of stored entries
//   overflow_err : sticky, set when a command was dropped
module tlx_afu_cmd_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PA_W  = 64
) (
  input  logic                 ha_pclock,
  input  logic                 ha_preset_n,
  tlx_afu_cmd_buffer_if.slave  cmd_if,
  output logic [4:0]           occupancy,
  output logic                 overflow_err
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DepthC = 5'(DEPTH);

  typedef struct packed {
    logic [7:0]      opcode;
    logic [15:0]     capptag;
    logic [PA_W-1:0] pa;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic            credit_q;
  logic            ovf_q, ovf_d;

  logic   full;
  logic   not_empty;
  logic   push;
  logic   pop;
  entry_t wr_entry;
  entry_t head;

  always_comb begin
    full      = (count_q == DepthC);
    not_empty = (count_q != 5'd0);
    pop       = not_empty & cmd_if.cmd_out_ready;
    // A full buffer still accepts when the head leaves in the same cycle.
    push      = cmd_if.tlx_afu_cmd_valid & (~full | pop);
    wr_entry  = '{opcode:  cmd_if.tlx_afu_cmd_opcode,
                  capptag: cmd_if.tlx_afu_cmd_capptag,
                  pa:      cmd_if.tlx_afu_cmd_pa};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    if (cmd_if.tlx_afu_cmd_valid && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
    if (!ha_preset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= pop;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; count alone decides which entries are meaningful.
  always_ff @(posedge ha_pclock) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    head                              = mem_q[rd_ptr_q];
    cmd_if.cmd_out_valid              = not_empty;
    cmd_if.cmd_out_opcode             = head.opcode;
    cmd_if.cmd_out_capptag            = head.capptag;
    cmd_if.cmd_out_pa                 = head.pa;
    cmd_if.afu_tlx_cmd_credit         = credit_q;
    cmd_if.afu_tlx_cmd_initial_credit = DepthC;
    occupancy                         = count_q;
    overflow_err                      = ovf_q;
  end

endmodule

// File: tb/tb_tlx_afu_cmd_buffer.sv
module tb_tlx_afu_cmd_buffer;

  localparam int unsigned Depth = 8;
  localparam int unsigned PaW   = 64;

  logic clk;
  logic rst_n;

  tlx_afu_cmd_buffer_if #(.PA_W(PaW)) cif ();
  logic [4:0] occupancy;
  logic       overflow_err;

  tlx_afu_cmd_buffer #(.DEPTH(Depth), .PA_W(PaW)) dut (
    .ha_pclock    (clk),
    .ha_preset_n  (rst_n),
    .cmd_if       (cif),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: a plain FIFO of commands plus a few scalars.
  typedef struct {
    logic [7:0]     op;
    logic [15:0]    tag;
    logic [PaW-1:0] pa;
  } cmd_t;

  cmd_t        mq[$];
  logic        m_ovf = 1'b0;
  logic        m_credit = 1'b0;
  int          m_pops = 0;
  logic [15:0] accepted[$];
  logic [15:0] obs[$];
  int          dut_credits = 0;
  bit          seen_ff = 0;

  task automatic drive(input logic v, input logic [7:0] op, input logic [15:0] tag,
                       input logic [PaW-1:0] pa, input logic rdy);
    cif.tlx_afu_cmd_valid   = v;
    cif.tlx_afu_cmd_opcode  = op;
    cif.tlx_afu_cmd_capptag = tag;
    cif.tlx_afu_cmd_pa      = pa;
    cif.cmd_out_ready       = rdy;
  endtask

  // Called at the negedge: compare DUT outputs to the model, then advance the model
  // by what the coming rising edge will do.
  task automatic model_check_and_advance();
    cmd_t c;
    bit   m_pop;
    bit   m_push;
    check("valid", 64'(cif.cmd_out_valid), 64'(mq.size() != 0));
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    check("credit", 64'(cif.afu_tlx_cmd_credit), 64'(m_credit));
    check("overflow", 64'(overflow_err), 64'(m_ovf));
    check("init_credit", 64'(cif.afu_tlx_cmd_initial_credit), 64'(Depth));
    if (mq.size() != 0) begin
      check("head_opcode", 64'(cif.cmd_out_opcode), 64'(mq[0].op));
      check("head_tag", 64'(cif.cmd_out_capptag), 64'(mq[0].tag));
      check("head_pa", 64'(cif.cmd_out_pa), 64'(mq[0].pa));
    end
    if (cif.cmd_out_valid === 1'b1 && cif.cmd_out_capptag === 16'h00FF) seen_ff = 1;
    if (cif.cmd_out_valid === 1'b1 && cif.cmd_out_ready === 1'b1) obs.push_back(cif.cmd_out_capptag);
    if (cif.afu_tlx_cmd_credit === 1'b1) dut_credits++;

    m_pop  = (mq.size() != 0) && cif.cmd_out_ready;
    m_push = cif.tlx_afu_cmd_valid && ((mq.size() < Depth) || m_pop);
    if (cif.tlx_afu_cmd_valid && !m_push) m_ovf = 1'b1;
    m_credit = m_pop;
    if (m_pop) begin
      void'(mq.pop_front());
      m_pops++;
    end
    if (m_push) begin
      c.op  = cif.tlx_afu_cmd_opcode;
      c.tag = cif.tlx_afu_cmd_capptag;
      c.pa  = cif.tlx_afu_cmd_pa;
      mq.push_back(c);
      accepted.push_back(c.tag);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] op, input logic [15:0] tag,
                      input logic [PaW-1:0] pa, input logic rdy);
    drive(v, op, tag, pa, rdy);
    @(negedge clk);
    model_check_and_advance();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic           v;
    logic [7:0]     op;
    logic [15:0]    tag;
    logic [PaW-1:0] pa;
    logic           rdy;
    logic           e_valid;
    logic [15:0]    e_tag;
    logic [4:0]     e_occ;
    logic           e_credit;
    logic           e_ovf;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cr0;
    int pops0;
    int cyc;
    int npush;

    // Single command through an empty buffer, then its credit.
    vecs[0] = '{1'b1, 8'h20, 16'h0001, 64'h0000_0000_0000_1000, 1'b1,
                1'b0, 16'h0000, 5'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 16'h0000, 64'h0, 1'b1,
                1'b1, 16'h0001, 5'd1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 16'h0000, 64'h0, 1'b1,
                1'b0, 16'h0000, 5'd0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 16'h0000, 64'h0, 1'b1,
                1'b0, 16'h0000, 5'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 8'h0, 16'h0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(cif.cmd_out_valid), 64'(0));
    check("rst_occ", 64'(occupancy), 64'(0));
    check("rst_credit", 64'(cif.afu_tlx_cmd_credit), 64'(0));
    check("rst_ovf", 64'(overflow_err), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].v, vecs[i].op, vecs[i].tag, vecs[i].pa, vecs[i].rdy);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 64'(cif.cmd_out_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(vecs[i].e_occ));
      check($sformatf("vec%0d_credit", i), 64'(cif.afu_tlx_cmd_credit), 64'(vecs[i].e_credit));
      check($sformatf("vec%0d_ovf", i), 64'(overflow_err), 64'(vecs[i].e_ovf));
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_tag", i), 64'(cif.cmd_out_capptag), 64'(vecs[i].e_tag));
        check($sformatf("vec%0d_op", i), 64'(cif.cmd_out_opcode), 64'(8'h20));
      end
      model_check_and_advance();
      @(posedge clk);
      #1;
    end

    // Fill to DEPTH with the AFU stalled; head must stay put.
    cr0   = dut_credits;
    obs.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 16'(i), {$urandom, $urandom}, 1'b0);
    repeat (2) step(1'b0, 8'h0, 16'h0, '0, 1'b0);
    check("full_occ", 64'(occupancy), 64'(8));
    check("full_head_tag", 64'(cif.cmd_out_capptag), 64'(0));

    // Push into a full buffer without a pop: dropped.
    step(1'b1, 8'hAA, 16'h00FF, 64'hDEAD, 1'b0);
    check("drop_occ", 64'(occupancy), 64'(8));
    check("drop_ovf", 64'(overflow_err), 64'(1));

    // Push into a full buffer with a simultaneous pop: accepted.
    step(1'b1, 8'h30, 16'h0009, 64'hBEEF, 1'b1);
    check("swap_occ", 64'(occupancy), 64'(8));

    repeat (10) step(1'b0, 8'h0, 16'h0, '0, 1'b1);
    check("drain_count", 64'(obs.size()), 64'(9));
    if (obs.size() == 9) begin
      for (int i = 0; i < 8; i++)
        check($sformatf("drain_order%0d", i), 64'(obs[i]), 64'(i));
      check("last_is_9", 64'(obs[8]), 64'(16'h0009));
    end
    check("credit_pulses", 64'(dut_credits - cr0), 64'(9));
    check("no_ff_out", 64'(seen_ff), 64'(0));
    check("ovf_sticky", 64'(overflow_err), 64'(1));

    // Random traffic across several pointer wraps.
    accepted.delete();
    obs.delete();
    cr0   = dut_credits;
    pops0 = m_pops;
    npush = 0;
    cyc   = 0;
    while (accepted.size() < 20 && cyc < 200) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 16'(16'h0300 + npush),
           {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      npush = accepted.size();
      cyc++;
    end
    check("rand_pushes", 64'(accepted.size()), 64'(20));
    repeat (12) step(1'b0, 8'h0, 16'h0, '0, 1'b1);
    check("rand_out_count", 64'(obs.size()), 64'(accepted.size()));
    if (obs.size() == accepted.size())
      for (int i = 0; i < obs.size(); i++)
        check($sformatf("rand_order%0d", i), 64'(obs[i]), 64'(accepted[i]));
    check("rand_credits", 64'(dut_credits - cr0), 64'(m_pops - pops0));

    // Asynchronous reset with 5 entries, overflow set and a credit in flight.
    for (int i = 0; i < 8; i++) step(1'b1, 8'h40, 16'(16'h0100 + i), '0, 1'b0);
    step(1'b1, 8'h40, 16'h01FF, '0, 1'b0);
    repeat (3) step(1'b0, 8'h0, 16'h0, '0, 1'b1);
    check("pre_rst_occ", 64'(occupancy), 64'(5));
    check("pre_rst_ovf", 64'(overflow_err), 64'(1));
    check("pre_rst_credit", 64'(cif.afu_tlx_cmd_credit), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(cif.cmd_out_valid), 64'(0));
    check("arst_occ", 64'(occupancy), 64'(0));
    check("arst_credit", 64'(cif.afu_tlx_cmd_credit), 64'(0));
    check("arst_ovf", 64'(overflow_err), 64'(0));
    drive(1'b1, 8'h55, 16'h0555, '0, 1'b1);
    @(posedge clk);
    #1;
    check("rst_ignore_occ", 64'(occupancy), 64'(0));
    check("rst_ignore_valid", 64'(cif.cmd_out_valid), 64'(0));
    drive(1'b0, 8'h0, 16'h0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_ovf    = 1'b0;
    m_credit = 1'b0;
    obs.delete();
    @(posedge clk);
    #1;
    step(1'b1, 8'h21, 16'h0042, 64'h4242, 1'b1);
    repeat (3) step(1'b0, 8'h0, 16'h0, '0, 1'b1);
    check("post_rst_count", 64'(obs.size()), 64'(1));
    if (obs.size() != 0) check("post_rst_first", 64'(obs[0]), 64'(16'h0042));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
